// File: rtl/demux_1_pkg.sv
// Shared types and constants for the registered 1-to-4 demultiplexer.
package demux_1_pkg;

    localparam int DEMUX_WIDTH_DEFAULT = 1;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_D0 = 2'b00;
    localparam sel_t SEL_D1 = 2'b01;
    localparam sel_t SEL_D2 = 2'b10;
    localparam sel_t SEL_D3 = 2'b11;

endpackage

// File: rtl/demux_1_dec.sv
// Purely combinational 2-to-4 one-hot select decoder.
module demux_1_dec
    import demux_1_pkg::*;
(
    input  sel_t       sel,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = 4'b0000;
        case (sel)
            SEL_D0:  onehot = 4'b0001;
            SEL_D1:  onehot = 4'b0010;
            SEL_D2:  onehot = 4'b0100;
            SEL_D3:  onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
    end

endmodule

// File: rtl/demux_1.sv
// Registered 1-to-4 demultiplexer: routes d to one of d0..d3 each edge,
// zeroing the others, and flags select changes with a one-cycle pulse.
module demux_1
    import demux_1_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] d3,
    output logic [1:0]       sel_q,
    output logic             sel_chg
);

    sel_t             sel_next;
    logic [3:0]       onehot;
    logic [WIDTH-1:0] out_next [4];
    logic [WIDTH-1:0] out_reg  [4];
    sel_t             sel_q_reg;
    logic             sel_chg_next;
    logic             sel_chg_reg;

    assign sel_next = {s1, s0};

    demux_1_dec u_dec (
        .sel    (sel_next),
        .onehot (onehot)
    );

    // Unselected lanes load zero so only one output is ever non-zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign out_next[gi] = onehot[gi] ? d : '0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_reg[gi] <= '0;
                end else begin
                    out_reg[gi] <= out_next[gi];
                end
            end
        end
    endgenerate

    // Change is judged against the held select, which resets to 00.
    assign sel_chg_next = (sel_next != sel_q_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q_reg   <= SEL_D0;
            sel_chg_reg <= 1'b0;
        end else begin
            sel_q_reg   <= sel_next;
            sel_chg_reg <= sel_chg_next;
        end
    end

    assign d0      = out_reg[0];
    assign d1      = out_reg[1];
    assign d2      = out_reg[2];
    assign d3      = out_reg[3];
    assign sel_q   = sel_q_reg;
    assign sel_chg = sel_chg_reg;

endmodule

// File: tb/tb_demux_1.sv
// Scoreboard bench for demux_1: runs a WIDTH=8 and a WIDTH=1 instance in
// lockstep against directed vectors with hand-written expectations.
module tb_demux_1;

    typedef struct {
        logic [7:0] d;
        logic [1:0] sel;
        logic       chg;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d;
    logic       s1, s0;

    logic [7:0] w8_d0, w8_d1, w8_d2, w8_d3;
    logic [1:0] w8_sel_q;
    logic       w8_sel_chg;
    logic       w1_d0, w1_d1, w1_d2, w1_d3;
    logic [1:0] w1_sel_q;
    logic       w1_sel_chg;

    int total = 0;
    int bad   = 0;

    vec_t exp_q [$];
    vec_t last_e;
    vec_t vecs [17];

    always #5 clk = ~clk;

    demux_1 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .d(d), .s1(s1), .s0(s0),
        .d0(w8_d0), .d1(w8_d1), .d2(w8_d2), .d3(w8_d3),
        .sel_q(w8_sel_q), .sel_chg(w8_sel_chg)
    );

    demux_1 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .d(d[0]), .s1(s1), .s0(s0),
        .d0(w1_d0), .d1(w1_d1), .d2(w1_d2), .d3(w1_d3),
        .sel_q(w1_sel_q), .sel_chg(w1_sel_chg)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output of both instances against one expected record.
    task automatic check_all(input string tag, input vec_t e);
        logic [7:0] a8 [4];
        logic       a1 [4];
        logic [7:0] ex;
        a8[0] = w8_d0; a8[1] = w8_d1; a8[2] = w8_d2; a8[3] = w8_d3;
        a1[0] = w1_d0; a1[1] = w1_d1; a1[2] = w1_d2; a1[3] = w1_d3;
        for (int n = 0; n < 4; n++) begin
            ex = (int'(e.sel) == n) ? e.d : 8'h00;
            check($sformatf("%s w8 d%0d", tag, n), a8[n], ex);
            check($sformatf("%s w1 d%0d", tag, n), {7'b0, a1[n]}, {7'b0, ex[0]});
        end
        check({tag, " w8 sel_q"},   {6'b0, w8_sel_q},   {6'b0, e.sel});
        check({tag, " w1 sel_q"},   {6'b0, w1_sel_q},   {6'b0, e.sel});
        check({tag, " w8 sel_chg"}, {7'b0, w8_sel_chg}, {7'b0, e.chg});
        check({tag, " w1 sel_chg"}, {7'b0, w1_sel_chg}, {7'b0, e.chg});
    endtask

    task automatic check_reset(input string tag);
        vec_t z;
        z.d = 8'h00; z.sel = 2'b00; z.chg = 1'b0;
        check_all(tag, z);
    endtask

    task automatic drive_vec(input int idx);
        d = vecs[idx].d;
        {s1, s0} = vecs[idx].sel;
        exp_q.push_back(vecs[idx]);
        $display("issue vec%0d d=%h sel=%b exp_chg=%b", idx, vecs[idx].d, vecs[idx].sel, vecs[idx].chg);
    endtask

    task automatic step(input int idx);
        @(negedge clk);
        #1;
        drive_vec(idx);
    endtask

    // Monitor: every falling edge follows a routing edge; pop and compare.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                last_e = exp_q.pop_front();
                check_all($sformatf("edge d=%h sel=%b", last_e.d, last_e.sel), last_e);
            end
        end
    end

    initial begin
        // Directed vectors: d, select, expected sel_chg after the edge.
        vecs[0]  = '{8'h01, 2'b00, 1'b0};
        vecs[1]  = '{8'h01, 2'b01, 1'b1};
        vecs[2]  = '{8'h01, 2'b10, 1'b1};
        vecs[3]  = '{8'h01, 2'b11, 1'b1};
        vecs[4]  = '{8'h00, 2'b00, 1'b1};
        vecs[5]  = '{8'h00, 2'b01, 1'b1};
        vecs[6]  = '{8'h00, 2'b10, 1'b1};
        vecs[7]  = '{8'h00, 2'b11, 1'b1};
        vecs[8]  = '{8'hA5, 2'b10, 1'b1};
        vecs[9]  = '{8'hA5, 2'b10, 1'b0};
        vecs[10] = '{8'hA5, 2'b10, 1'b0};
        vecs[11] = '{8'h5A, 2'b10, 1'b0};
        vecs[12] = '{8'hFF, 2'b11, 1'b1};
        vecs[13] = '{8'h3C, 2'b01, 1'b1};
        vecs[14] = '{8'h77, 2'b00, 1'b1};
        vecs[15] = '{8'h77, 2'b00, 1'b0};
        vecs[16] = '{8'h81, 2'b11, 1'b1};

        rst_n = 1'b1;
        d = 8'hFF;
        {s1, s0} = 2'b11;
        #1 rst_n = 1'b0;
        #1 check_reset("reset no clk");
        repeat (2) @(posedge clk);
        #1 check_reset("reset held over edges");

        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive_vec(0);
        for (int i = 1; i <= 12; i++) step(i);

        // Mid-cycle reset while d3 holds FF; release before the next edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("mid-cycle reset");
        drive_vec(13);
        #1 rst_n = 1'b1;

        // Toggle d without a clock edge; outputs must hold.
        @(negedge clk);
        #2 d = 8'hC3;
        #1 check_all("d toggle no edge", last_e);
        d = 8'h3C;

        for (int i = 14; i <= 16; i++) step(i);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_1.md
DEMUX_1 -- requirements
Module: demux_1

Interface
REQ-001 Parameter WIDTH, default 1, bit width of the data input d and of each output d0..d3.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 d  input  WIDTH  data to route.
REQ-005 s1  input  1  select MSB.
REQ-006 s0  input  1  select LSB.
REQ-007 d0  output  WIDTH  routed data for select 00.
REQ-008 d1  output  WIDTH  routed data for select 01.
REQ-009 d2  output  WIDTH  routed data for select 10.
REQ-010 d3  output  WIDTH  routed data for select 11.
REQ-011 sel_q  output  2  registered select {s1,s0} of the last clock edge.
REQ-012 sel_chg  output  1  one-cycle pulse: registered select differs from its previous value.

Function
REQ-013 Each rising clk edge SHALL sample d, s1 and s0 together.
- Select 00 loads d into d0, 01 into d1, 10 into d2, 11 into d3.
REQ-014 Every output not selected on that edge SHALL load all-zeros.
- Exactly one output can be non-zero at a time, and it carries d.
REQ-015 Latency SHALL be exactly one clk cycle from input sample to output.
- No combinational path from d, s1 or s0 to any output.
REQ-016 sel_q SHALL load {s1,s0} on every edge.
REQ-017 sel_chg SHALL be 1 for the one cycle after an edge where the new sel_q differs from the old sel_q, else 0.
REQ-018 The first edge after reset release SHALL compare against the reset sel_q value of 00.
REQ-019 There is no enable and no handshake: routing occurs on every edge.
REQ-020 Select or data values held constant across edges SHALL keep the outputs constant.
REQ-021 X or Z on s1/s0 is outside scope; the bench SHALL drive only 0 and 1.

Reset
REQ-022 While rst_n is 0, outputs SHALL be forced immediately, independent of clk:
- d0..d3 = 0
- sel_q = 00
- sel_chg = 0
REQ-023 Reset asserted mid-operation SHALL clear all outputs within the same cycle.
REQ-024 The first routing edge SHALL be the first rising clk with rst_n already 1.
REQ-025 rst_n release SHALL be synchronized externally to clk; demux_1 contains no reset synchronizer.

Structure
REQ-026 Shared package demux_1_pkg SHALL hold:
- the default WIDTH constant;
- the 2-bit select typedef;
- named select constants SEL_D0..SEL_D3 = 00, 01, 10, 11.
REQ-027 One sub-module demux_1_dec SHALL perform the purely combinational 2-to-4 one-hot decode.
- demux_1 registers the gated data and the select/change logic.

Verification
REQ-028 Reset with rst_n=0 while d=1 and s1,s0=11 -> all of d0..d3, sel_q and sel_chg read 0, with no clk edge needed.
REQ-029 WIDTH=1, rst_n=1, d=1, sweep s1s0 00,01,10,11, one edge each -> after each edge only d0, d1, d2, d3 respectively is 1, the rest 0; sel_chg=1 after edges 2-4.
REQ-030 d=0 with each select value -> d0..d3 all 0 after every edge; sel_q tracks the select.
REQ-031 WIDTH=8, d=8'hA5, s1s0=10 held for 3 edges -> d2=8'hA5 and the others 0 on all 3 cycles; sel_chg=1 only after the first edge.
REQ-032 rst_n pulled low mid-cycle while d3=1 -> d3 clears immediately; after release, the next edge routes normally.
REQ-033 d toggled between edges without a clk edge -> outputs unchanged until the next rising edge.
